jk_excite_driver: RTL and testbench
===================================

# jk_excite_driver

Sequential driver for a bank of external JK flip-flops. It accepts a target register value over a valid/ready handshake and computes the per-bit J/K excitation from the bank's current Q. It drives J/K for exactly one clock, then checks the bank's Q against the target and reports done or mismatch. It is the driving end of the JK flip-flop interface, used wherever a JK register bank must be loaded with an arbitrary value.

## Interface
- WIDTH, 4: number of JK flip-flops driven; width of target, J, K and Q feedback.
- USE_TOGGLE, 0: 0 = changing bits use set/reset excitation (J=1,K=0 / J=0,K=1); 1 = changing bits use toggle excitation (J=1,K=1).

- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low (reset asserted while low).
- tgt_valid  input  1  target word valid.
- tgt_data  input  WIDTH  requested next value of the JK bank.
- tgt_ready  output  1  block can accept a target this cycle.
- j  output  WIDTH  J inputs to the JK bank, registered.
- k  output  WIDTH  K inputs to the JK bank, registered.
- q_fb  input  WIDTH  Q outputs of the JK bank.
- busy  output  1  high in DRIVE and CHECK.
- done  output  1  one-cycle pulse when Q matched the target.
- mismatch  output  1  one-cycle pulse when Q did not match the target.
- err_count  output  8  count of mismatches, saturating at 255.

## Operation
- FSM states: IDLE, DRIVE, CHECK. Reset state is IDLE.
- IDLE:
  - tgt_ready=1.
  - On tgt_valid&&tgt_ready at an edge: latch tgt_data into target register, register j/k from excitation(tgt_data, q_fb) sampled at that edge, go to DRIVE.
- Excitation, per bit i with t=tgt_data[i], q=q_fb[i]:
  - t==q: j=0, k=0 (hold).
  - t=1, q=0: USE_TOGGLE=0 gives j=1,k=0; USE_TOGGLE=1 gives j=1,k=1.
  - t=0, q=1: USE_TOGGLE=0 gives j=0,k=1; USE_TOGGLE=1 gives j=1,k=1.
  - The J=K=1 pattern never appears on an unchanging bit.
- DRIVE: j/k hold the excitation for exactly one cycle; the bank samples it at the next edge. At that edge j,k←0 and the FSM goes to CHECK.
- CHECK: j=k=0. At the next edge compare q_fb with the target register:
  - Equal: done←1.
  - Not equal: mismatch←1 and err_count←err_count+1, unless already 255.
  - Go to IDLE.
- done and mismatch are registered and high for exactly one cycle; they are mutually exclusive.
- tgt_valid while tgt_ready=0 is ignored. The source holds it; nothing is queued.
- tgt_data is sampled only at the accept edge; later changes have no effect.
- Reset asserted (low), at any time including mid-DRIVE:
  - Immediately: state=IDLE, j=0, k=0, done=0, mismatch=0, busy=0, err_count=0, target register=0, tgt_ready=0.
  - tgt_ready rises to 1 in the first cycle after reset deasserts.

## Timing
- Accept at edge N.
- j/k valid in cycle N→N+1; busy=1 in cycles N→N+2.
- Bank updates at edge N+1; q_fb is compared at edge N+2.
- done/mismatch high in cycle N+2→N+3, coincident with tgt_ready=1.
- Next accept possible at edge N+3. Max throughput is one target per 3 cycles.
- The target-to-result latency is fixed at 2 edges after accept, independent of data or USE_TOGGLE.
- q_fb must settle within one cycle of the bank's clock edge; the bank uses the same clk.

## Test plan
- Reset, then check idle: hold reset low with tgt_valid=1 → j=k=0, done=mismatch=busy=0, tgt_ready=0, err_count=0. Release reset → tgt_ready=1 next cycle.
- Set/reset excitation: WIDTH=4, USE_TOGGLE=0, bank Q=4'b0011, target 4'b0101 → during DRIVE j=4'b0100, k=4'b0010. Q becomes 4'b0101 and done pulses at N+2.
- Toggle excitation: USE_TOGGLE=1, Q=4'b0011, target 4'b0101 → j=k=4'b0110 for one cycle, then done.
- Hold-only target: target equals current Q=4'b1010 → j=k=0 throughout, done pulses, Q unchanged.
- Mismatch with saturation: model a bank bit stuck at 0 and request 4'b1111 three times → three mismatch pulses, err_count=3. Preload the counter to 255 and repeat → err_count stays 255.
- Reset mid-operation: assert reset during DRIVE → j/k drop to 0 immediately, no done/mismatch pulse, FSM in IDLE. Back-to-back tgt_valid held high → accepts spaced exactly 3 cycles apart.

Source files
------------

// File: rtl/jk_excite_driver.sv
// jk_excite_driver: loads an external JK flip-flop bank with a target word, then verifies it.
module jk_excite_driver #(
  parameter int WIDTH      = 4,
  parameter bit USE_TOGGLE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_data,
  output logic             tgt_ready,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] q_fb,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [7:0]       err_count
);
  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d, j_q, j_d, k_q, k_d, chg;
  logic done_q, done_d, mismatch_q, mismatch_d, rdy_q;
  logic [7:0] err_count_q, err_count_d;
  logic accept;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      tgt_q       <= '0;
      j_q         <= '0;
      k_q         <= '0;
      done_q      <= 1'b0;
      mismatch_q  <= 1'b0;
      err_count_q <= '0;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      j_q         <= j_d;
      k_q         <= k_d;
      done_q      <= done_d;
      mismatch_q  <= mismatch_d;
      err_count_q <= err_count_d;
      rdy_q       <= 1'b1;
    end
  end
  // rdy_q keeps the block from accepting on the first edge after reset release
  assign tgt_ready = rdy_q && state_q == IDLE;
  assign accept    = tgt_valid && tgt_ready;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? DRIVE : IDLE;
      DRIVE:   state_d = CHECK;
      default: state_d = IDLE;
    endcase
  end
  assign chg = tgt_data ^ q_fb;
  always_comb begin
    tgt_d       = accept ? tgt_data : tgt_q;
    j_d         = accept ? chg : '0;
    k_d         = accept ? (USE_TOGGLE ? chg : chg & ~tgt_data) : '0;
    j_d         = (accept && !USE_TOGGLE) ? chg & tgt_data : j_d;
    done_d      = state_q == CHECK && q_fb == tgt_q;
    mismatch_d  = state_q == CHECK && q_fb != tgt_q;
    err_count_d = (mismatch_d && err_count_q != 8'hff) ? err_count_q + 8'd1 : err_count_q;
  end
  assign j         = j_q;
  assign k         = k_q;
  assign busy      = state_q != IDLE;
  assign done      = done_q;
  assign mismatch  = mismatch_q;
  assign err_count = err_count_q;
endmodule

// File: tb/tb_jk_excite_driver.sv
// tb_jk_excite_driver: drives set/reset and toggle variants against behavioural JK banks.
module tb_jk_excite_driver;
  logic clk = 0, reset = 0, tgt_valid = 0;
  logic [3:0] tgt_data = 4'hf;
  logic rdy0, rdy1, busy0, busy1, done0, done1, mis0, mis1;
  logic [3:0] j0, k0, j1, k1, b0, b1;
  logic [7:0] err0, err1;
  logic bank_ld = 0;
  logic [3:0] bank_val = 0, stuck = 0;
  int n_cmp = 0, n_bad = 0, exp_err = 0;

  always #5 clk = ~clk;

  jk_excite_driver #(.WIDTH(4), .USE_TOGGLE(1'b0)) dut0 (.clk(clk), .reset(reset),
    .tgt_valid(tgt_valid), .tgt_data(tgt_data), .tgt_ready(rdy0), .j(j0), .k(k0), .q_fb(b0),
    .busy(busy0), .done(done0), .mismatch(mis0), .err_count(err0));
  jk_excite_driver #(.WIDTH(4), .USE_TOGGLE(1'b1)) dut1 (.clk(clk), .reset(reset),
    .tgt_valid(tgt_valid), .tgt_data(tgt_data), .tgt_ready(rdy1), .j(j1), .k(k1), .q_fb(b1),
    .busy(busy1), .done(done1), .mismatch(mis1), .err_count(err1));

  function automatic logic [3:0] jk_next(input logic [3:0] q, input logic [3:0] jj, input logic [3:0] kk);
    for (int i = 0; i < 4; i++)
      jk_next[i] = (jj[i] && kk[i]) ? !q[i] : jj[i] ? 1'b1 : kk[i] ? 1'b0 : q[i];
  endfunction

  // Bank model: plain JK characteristic, with optional stuck-at-0 bits
  always @(posedge clk) begin
    b0 <= bank_ld ? bank_val : jk_next(b0, j0, k0) & ~stuck;
    b1 <= bank_ld ? bank_val : jk_next(b1, j1, k1) & ~stuck;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic excite(input logic [3:0] t, input logic [3:0] q, input bit tog,
                        output logic [3:0] ej, output logic [3:0] ek);
    for (int i = 0; i < 4; i++) begin
      ej[i] = 0;
      ek[i] = 0;
      if (t[i] && !q[i]) begin ej[i] = 1; ek[i] = tog; end
      if (!t[i] && q[i]) begin ej[i] = tog; ek[i] = 1; end
    end
  endtask

  task automatic run_txn(input logic [3:0] q, input logic [3:0] t, input logic [3:0] st,
                         input logic [3:0] ej0, input logic [3:0] ek0,
                         input logic [3:0] ej1, input logic [3:0] ek1, input logic edone);
    stuck = st;
    bank_val = q & ~st;
    bank_ld = 1;
    step();
    bank_ld = 0;
    tgt_valid = 1;
    tgt_data = t;
    step();
    tgt_valid = 0;
    tgt_data = ~t;
    chk("drive_j0", j0, ej0); chk("drive_k0", k0, ek0);
    chk("drive_j1", j1, ej1); chk("drive_k1", k1, ek1);
    chk("drive_busy", busy0, 1); chk("drive_ready", rdy0, 0);
    step();
    chk("check_jk0", {j0, k0}, 0); chk("check_jk1", {j1, k1}, 0);
    chk("check_busy", busy1, 1);
    chk("bank0", b0, t & ~st); chk("bank1", b1, t & ~st);
    chk("check_pulses", {done0, mis0}, 0);
    step();
    if (!edone && exp_err < 255) exp_err++;
    chk("done0", done0, edone); chk("mis0", mis0, !edone);
    chk("done1", done1, edone); chk("mis1", mis1, !edone);
    chk("result_ready", rdy0, 1); chk("result_busy", busy0, 0);
    chk("err0", err0, exp_err); chk("err1", err1, exp_err);
    step();
    chk("pulse_end", {done0, mis0, done1, mis1}, 0);
  endtask

  typedef struct {
    logic [3:0] q, t, st, j0, k0, j1, k1;
    logic dn;
  } vec_t;

  initial begin
    vec_t vecs[7];
    int acc[$];
    logic prev;
    logic [3:0] rq, rt, rs, ej0, ek0, ej1, ek1;
    vecs[0] = '{4'b0011, 4'b0101, 4'b0000, 4'b0100, 4'b0010, 4'b0110, 4'b0110, 1'b1};
    vecs[1] = '{4'b1010, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1};
    vecs[2] = '{4'b0000, 4'b1111, 4'b0001, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 1'b0};
    vecs[3] = '{4'b0000, 4'b1111, 4'b0001, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 1'b0};
    vecs[4] = '{4'b0000, 4'b1111, 4'b0001, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 1'b0};
    vecs[5] = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 1'b1};
    vecs[6] = '{4'b1001, 4'b0110, 4'b0000, 4'b0110, 4'b1001, 4'b1111, 4'b1111, 1'b1};
    tgt_valid = 1;
    step();
    step();
    chk("rst_jk", {j0, k0, j1, k1}, 0);
    chk("rst_pulses", {done0, mis0, done1, mis1}, 0);
    chk("rst_busy", {busy0, busy1}, 0);
    chk("rst_ready", {rdy0, rdy1}, 0);
    chk("rst_err", {err0, err1}, 0);
    reset = 1;
    #1;
    chk("rel_ready_low", rdy0, 0);
    step();
    chk("rel_ready_high", {rdy0, rdy1}, 2'b11);
    chk("rel_no_accept", busy0, 0);
    tgt_valid = 0;
    foreach (vecs[i])
      run_txn(vecs[i].q, vecs[i].t, vecs[i].st, vecs[i].j0, vecs[i].k0, vecs[i].j1, vecs[i].k1, vecs[i].dn);
    chk("err_after_table", err0, 3);
    for (int n = 0; n < 40; n++) begin
      rq = 4'($urandom);
      rt = 4'($urandom);
      rs = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
      excite(rt, rq & ~rs, 1'b0, ej0, ek0);
      excite(rt, rq & ~rs, 1'b1, ej1, ek1);
      run_txn(rq, rt, rs, ej0, ek0, ej1, ek1, (rt & ~rs) == rt);
    end
    for (int n = 0; n < 256; n++)
      run_txn(4'b0000, 4'b1111, 4'b0001, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 1'b0);
    chk("err_saturated", err0, 255);
    stuck = 0;
    bank_val = 4'b0000;
    bank_ld = 1;
    step();
    bank_ld = 0;
    tgt_valid = 1;
    tgt_data = 4'b1111;
    step();
    tgt_valid = 0;
    reset = 0;
    #1;
    chk("mid_rst_jk", {j0, k0, j1, k1}, 0);
    chk("mid_rst_busy", {busy0, busy1}, 0);
    chk("mid_rst_ready", rdy0, 0);
    chk("mid_rst_err", err0, 0);
    exp_err = 0;
    #2 reset = 1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("mid_rst_no_pulse", {done0, mis0, done1, mis1}, 0);
      chk("mid_rst_idle", busy0, 0);
    end
    bank_val = 4'b0110;
    bank_ld = 1;
    step();
    bank_ld = 0;
    tgt_valid = 1;
    tgt_data = 4'b0110;
    prev = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (busy0 && !prev) acc.push_back(c);
      prev = busy0;
      chk("b2b_done", done0, c % 3 == 2);
    end
    tgt_valid = 0;
    chk("b2b_count", acc.size(), 4);
    for (int i = 1; i < acc.size(); i++) chk("b2b_spacing", acc[i] - acc[i-1], 3);
    step();
    step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
